// File: rtl/hazard_ctrl_if.sv
// Decode-side sequencing bundle between the core pipeline and hazard_ctrl.
// Performance counter signals exist only when HAZARD_PERF_EN is defined.
interface hazard_ctrl_if
`ifdef HAZARD_PERF_EN
   #(parameter int unsigned STALL_CNT_W = 16)
`endif
   ;
   logic [4:0] ID_rA;
   logic [4:0] ID_rB;
   logic       ID_rA_vld;
   logic       ID_rB_vld;
   logic       ID_is_br;
   logic       ID_br_ctrl;
   logic [4:0] EX_rD;
   logic       EX_wrEn;
   logic       EX_memEn;
   logic       EX_memwrEn;
   logic [4:0] MEM_rD;
   logic       MEM_wrEn;
   logic       MEM_memEn;
   logic       dmem_ack;
   logic       dmem_req;
   logic       pipe_freeze;
   logic       IF_stall;
   logic       ID_stall;
   logic       EX_bubble;
   logic       pc_sel;
   logic       IF_ID_flush;
`ifdef HAZARD_PERF_EN
   logic [STALL_CNT_W-1:0] stall_cycles;
   logic [STALL_CNT_W-1:0] flush_count;
   logic [STALL_CNT_W-1:0] freeze_cycles;
`endif

   modport master (
`ifdef HAZARD_PERF_EN
      input  stall_cycles, flush_count, freeze_cycles,
`endif
      output ID_rA, ID_rB, ID_rA_vld, ID_rB_vld, ID_is_br, ID_br_ctrl,
      output EX_rD, EX_wrEn, EX_memEn, EX_memwrEn, MEM_rD, MEM_wrEn, MEM_memEn, dmem_ack,
      input  dmem_req, pipe_freeze, IF_stall, ID_stall, EX_bubble, pc_sel, IF_ID_flush
   );

   modport slave (
`ifdef HAZARD_PERF_EN
      output stall_cycles, flush_count, freeze_cycles,
`endif
      input  ID_rA, ID_rB, ID_rA_vld, ID_rB_vld, ID_is_br, ID_br_ctrl,
      input  EX_rD, EX_wrEn, EX_memEn, EX_memwrEn, MEM_rD, MEM_wrEn, MEM_memEn, dmem_ack,
      output dmem_req, pipe_freeze, IF_stall, ID_stall, EX_bubble, pc_sel, IF_ID_flush
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use / branch-operand stall, branch redirect and data-memory freeze control.
// Define HAZARD_PERF_EN to add saturating stall/flush/freeze counters.
module hazard_ctrl
`ifdef HAZARD_PERF_EN
   #(parameter int unsigned STALL_CNT_W = 16)
`endif
(
   input logic          clk,
   input logic          reset,
   hazard_ctrl_if.slave bus
);

   typedef enum logic {StRun, StHaz} haz_state_e;
   typedef enum logic {StMemIdle, StMemWait} mem_state_e;

   haz_state_e haz_q, haz_d;
   mem_state_e mem_q, mem_d;
   logic [1:0] cnt_q, cnt_d;
   logic       ex_load, ld_hz, br_ex, br_mem;
   logic [1:0] stall_n;
   logic       freeze, stall, redirect, req;

   assign ex_load = bus.EX_memEn & ~bus.EX_memwrEn & bus.EX_wrEn;
   assign ld_hz   = ex_load & ((bus.ID_rA_vld & (bus.ID_rA == bus.EX_rD)) |
                               (bus.ID_rB_vld & (bus.ID_rB == bus.EX_rD)));
   assign br_ex   = bus.ID_is_br & bus.EX_wrEn & (bus.ID_rB == bus.EX_rD);
   assign br_mem  = bus.ID_is_br & bus.MEM_wrEn & (bus.ID_rB == bus.MEM_rD);
   assign stall_n = br_ex ? 2'd2 : ((ld_hz | br_mem) ? 2'd1 : 2'd0);

   always_comb begin
      mem_d  = mem_q;
      req    = 1'b0;
      freeze = 1'b0;
      case (mem_q)
         StMemIdle: begin
            if (bus.MEM_memEn) begin
               req    = 1'b1;
               freeze = 1'b1;
               mem_d  = StMemWait;
            end
         end
         StMemWait: begin
            // The pipeline advances on the edge that ends the ack cycle.
            if (bus.dmem_ack) mem_d = StMemIdle;
            else              freeze = 1'b1;
         end
         default: mem_d = StMemIdle;
      endcase
   end

   always_comb begin
      haz_d    = haz_q;
      cnt_d    = cnt_q;
      stall    = 1'b0;
      redirect = 1'b0;
      if (!freeze) begin
         case (haz_q)
            StRun: begin
               if (stall_n != 2'd0) begin
                  stall = 1'b1;
                  cnt_d = stall_n - 2'd1;
                  if (stall_n > 2'd1) haz_d = StHaz;
               end else if (bus.ID_br_ctrl) begin
                  redirect = 1'b1;
               end
            end
            StHaz: begin
               // Hazards are not re-evaluated until the remaining count drains.
               stall = 1'b1;
               cnt_d = cnt_q - 2'd1;
               if (cnt_q <= 2'd1) haz_d = StRun;
            end
            default: haz_d = StRun;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         haz_q <= StRun;
         cnt_q <= 2'd0;
         mem_q <= StMemIdle;
      end else begin
         haz_q <= haz_d;
         cnt_q <= cnt_d;
         mem_q <= mem_d;
      end
   end

   assign bus.dmem_req    = req;
   assign bus.pipe_freeze = freeze;
   assign bus.IF_stall    = stall;
   assign bus.ID_stall    = stall;
   assign bus.EX_bubble   = stall;
   assign bus.pc_sel      = redirect;
   assign bus.IF_ID_flush = redirect;

`ifdef HAZARD_PERF_EN
   logic [STALL_CNT_W-1:0] stall_cnt_q, flush_cnt_q, freeze_cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q  <= '0;
         flush_cnt_q  <= '0;
         freeze_cnt_q <= '0;
      end else begin
         if (stall && (stall_cnt_q != '1))     stall_cnt_q  <= stall_cnt_q + 1'b1;
         if (redirect && (flush_cnt_q != '1))  flush_cnt_q  <= flush_cnt_q + 1'b1;
         if (freeze && (freeze_cnt_q != '1))   freeze_cnt_q <= freeze_cnt_q + 1'b1;
      end
   end

   assign bus.stall_cycles  = stall_cnt_q;
   assign bus.flush_count   = flush_cnt_q;
   assign bus.freeze_cycles = freeze_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: hazards, redirect, memory freeze, reset abort.
module tb_hazard_ctrl;
   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad = 0;

   hazard_ctrl_if bus ();

   hazard_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // {dmem_req, pipe_freeze, IF_stall, ID_stall, EX_bubble, pc_sel, IF_ID_flush}
   logic [6:0] outs;
   assign outs = {bus.dmem_req, bus.pipe_freeze, bus.IF_stall, bus.ID_stall,
                  bus.EX_bubble, bus.pc_sel, bus.IF_ID_flush};

   localparam logic [6:0] IDLE = 7'b000_0000;
   localparam logic [6:0] STL  = 7'b001_1100;
   localparam logic [6:0] BR   = 7'b000_0011;
   localparam logic [6:0] REQ  = 7'b110_0000;
   localparam logic [6:0] FRZ  = 7'b010_0000;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic set_idle();
      bus.ID_rA = 5'd0;  bus.ID_rB = 5'd0;  bus.ID_rA_vld = 1'b0; bus.ID_rB_vld = 1'b0;
      bus.ID_is_br = 1'b0; bus.ID_br_ctrl = 1'b0;
      bus.EX_rD = 5'd0;  bus.EX_wrEn = 1'b0; bus.EX_memEn = 1'b0; bus.EX_memwrEn = 1'b0;
      bus.MEM_rD = 5'd0; bus.MEM_wrEn = 1'b0; bus.MEM_memEn = 1'b0;
      bus.dmem_ack = 1'b0;
   endtask

   // Inputs change 1 time unit after the edge, outputs are sampled 1 unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle_chk(input string tag, input logic [6:0] exp);
      #1;
      check_eq(tag, {25'd0, outs}, {25'd0, exp});
   endtask

   initial begin
      set_idle();
      reset = 1'b1;
      #12;
      check_eq("in_reset", {25'd0, outs}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      tick();
      settle_chk("post_reset", IDLE);

      // Load-use on rA, one stall cycle then clear once the load moves on.
      tick();
      bus.EX_memEn = 1'b1; bus.EX_wrEn = 1'b1; bus.EX_rD = 5'd5;
      bus.ID_rA = 5'd5; bus.ID_rA_vld = 1'b1;
      settle_chk("ld_c0", STL);
      tick();
      bus.EX_memEn = 1'b0; bus.EX_wrEn = 1'b0;
      settle_chk("ld_c1", IDLE);
      // Same indices but rA not read, and a store in EX: neither stalls.
      bus.EX_memEn = 1'b1; bus.EX_wrEn = 1'b1; bus.ID_rA_vld = 1'b0;
      settle_chk("ld_novld", IDLE);
      bus.ID_rA_vld = 1'b1; bus.EX_memwrEn = 1'b1;
      settle_chk("ld_store", IDLE);
      // Register 0 is compared like any other index, here through rB.
      tick();
      set_idle();
      bus.EX_memEn = 1'b1; bus.EX_wrEn = 1'b1; bus.EX_rD = 5'd0;
      bus.ID_rB = 5'd0; bus.ID_rB_vld = 1'b1;
      settle_chk("ld_r0", STL);
      tick();
      set_idle();
      settle_chk("ld_r0_done", IDLE);

      // Branch after ALU producer in EX: 2 stall cycles, redirect suppressed meanwhile.
      bus.ID_is_br = 1'b1; bus.ID_rB = 5'd3; bus.ID_br_ctrl = 1'b1;
      bus.EX_rD = 5'd3; bus.EX_wrEn = 1'b1;
      settle_chk("br_c0", STL);
      tick();
      bus.EX_wrEn = 1'b0; bus.MEM_wrEn = 1'b1; bus.MEM_rD = 5'd3;
      settle_chk("br_c1", STL);
      tick();
      bus.MEM_wrEn = 1'b0;
      settle_chk("br_taken", BR);
      tick();
      set_idle();
      settle_chk("br_done", IDLE);

      // Branch after producer in MEM: 1 stall cycle.
      bus.ID_is_br = 1'b1; bus.ID_rB = 5'd7; bus.MEM_wrEn = 1'b1; bus.MEM_rD = 5'd7;
      settle_chk("brm_c0", STL);
      tick();
      bus.MEM_wrEn = 1'b0;
      settle_chk("brm_c1", IDLE);
      tick();
      set_idle();

      // Memory access with ack 3 cycles after req; freeze masks hazards and redirect.
      bus.MEM_memEn = 1'b1;
      settle_chk("mem_req", REQ);
      tick();
      bus.ID_br_ctrl = 1'b1;
      settle_chk("mem_w1", FRZ);
      tick();
      bus.ID_br_ctrl = 1'b0;
      bus.EX_memEn = 1'b1; bus.EX_wrEn = 1'b1; bus.EX_rD = 5'd9;
      bus.ID_rA = 5'd9; bus.ID_rA_vld = 1'b1;
      settle_chk("mem_w2", FRZ);
      tick();
      set_idle();
      bus.MEM_memEn = 1'b1; bus.dmem_ack = 1'b1;
      settle_chk("mem_ack", IDLE);
      // Back-to-back access right after the ack, acked the following cycle.
      tick();
      bus.dmem_ack = 1'b0;
      settle_chk("b2b_req", REQ);
      tick();
      bus.dmem_ack = 1'b1;
      settle_chk("b2b_ack", IDLE);
      tick();
      set_idle();
      settle_chk("mem_idle", IDLE);

      // Freeze while in HAZ with cnt=1: remaining stall cycle resumes after ack.
      bus.ID_is_br = 1'b1; bus.ID_rB = 5'd3; bus.EX_rD = 5'd3; bus.EX_wrEn = 1'b1;
      settle_chk("fz_c0", STL);
      tick();
      bus.EX_wrEn = 1'b0; bus.MEM_memEn = 1'b1;
      settle_chk("fz_req", REQ);
      tick();
      settle_chk("fz_wait", FRZ);
      tick();
      bus.dmem_ack = 1'b1;
      settle_chk("fz_resume", STL);
      tick();
      set_idle();
      settle_chk("fz_done", IDLE);

`ifdef HAZARD_PERF_EN
      // Stalls: ld 1 + ld_r0 1 + br 2 + brm 1 + fz 2 = 7; one redirect;
      // freezes: mem 3 + b2b 1 + fz 2 = 6.
      check_eq("perf_stall", 32'(bus.stall_cycles), 32'd7);
      check_eq("perf_flush", 32'(bus.flush_count), 32'd1);
      check_eq("perf_freeze", 32'(bus.freeze_cycles), 32'd6);
`endif

      // Reset while waiting for ack; a late ack must not revive the access.
      tick();
      bus.MEM_memEn = 1'b1;
      settle_chk("rw_req", REQ);
      tick();
      bus.MEM_memEn = 1'b0;
      settle_chk("rw_wait", FRZ);
      reset = 1'b1;
      settle_chk("rw_reset", IDLE);
      tick();
      bus.dmem_ack = 1'b1;
      settle_chk("rw_ack_in_reset", IDLE);
      @(negedge clk);
      reset = 1'b0;
      tick();
      settle_chk("rw_late_ack", IDLE);
      tick();
      bus.dmem_ack = 1'b0;
      settle_chk("rw_after", IDLE);
`ifdef HAZARD_PERF_EN
      check_eq("perf_rst_stall", 32'(bus.stall_cycles), 32'd0);
      check_eq("perf_rst_freeze", 32'(bus.freeze_cycles), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
